// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the instruction-fetch responder and boot ROM.
package cpu_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [31:0] ROM_BASE  = 32'hFFFF_0000;

  typedef enum logic { IMEM_IDLE, IMEM_WAIT } imem_state_t;
  typedef enum logic { SRC_ROM, SRC_EXT } imem_src_t;

  // Boot image: every entry is a distinct word derived from its index.
  function automatic logic [31:0] boot_word(input logic [31:0] idx);
    return (idx * 32'h9E37_79B1) ^ 32'hB007_0000;
  endfunction

endpackage

// File: rtl/cpu_bootrom.sv
// Synchronous boot ROM; rdata updates only when en is high and otherwise holds.
// The image is built at elaboration time from cpu_pkg::boot_word.
module cpu_bootrom
  import cpu_pkg::*;
#(
  parameter int ROM_WORDS = 1024,
  parameter     ROM_INIT  = "boot.hex"
) (
  input  logic                         clock,
  input  logic                         en,
  input  logic [$clog2(ROM_WORDS)-1:0] addr,
  output logic [31:0]                  rdata
);

  logic [31:0] mem [ROM_WORDS];

  for (genvar i = 0; i < ROM_WORDS; i++) begin : g_img
    assign mem[i] = boot_word(32'(i));
  end

  always_ff @(posedge clock) begin
    if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_imem_resp.sv
// Instruction-bus responder: boot ROM served in one cycle, everything else via ibus req/ack
// with the CPU held on ifetch_stall. Define IMEM_LASTHIT_EN to add a one-entry last-fetch buffer.
module cpu_imem_resp
  import cpu_pkg::*;
#(
  parameter int ROM_WORDS = 1024,
  parameter     ROM_INIT  = "boot.hex"
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] p1_pc,
  output logic [31:0] p2_instr,
  output logic        ifetch_stall,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  input  logic        imem_inval
);

  localparam int AW = $clog2(ROM_WORDS);

  imem_state_t state, state_next;
  imem_src_t   src;
  logic [31:0] rom_data, ext_data, last_data;
  logic        advance, rom_hit, last_hit, fill;

  assign ifetch_stall = (state == IMEM_WAIT);
  assign ibus_req     = (state == IMEM_WAIT);
  assign advance      = !stall && !ifetch_stall;
  assign rom_hit      = (p1_pc[31:16] == ROM_BASE[31:16]);
  assign fill         = (state == IMEM_WAIT) && ibus_ack;

  logic unused_ok;
  assign unused_ok = ^p1_pc[1:0];

`ifdef IMEM_LASTHIT_EN
  logic        last_valid;
  logic [29:0] last_addr;

  assign last_hit = !rom_hit && last_valid && (p1_pc[31:2] == last_addr);

  // A fill on the same cycle as an invalidate keeps the freshly returned word.
  always_ff @(posedge clock) begin
    if (reset)           last_valid <= 1'b0;
    else if (fill)       last_valid <= 1'b1;
    else if (imem_inval) last_valid <= 1'b0;
    if (fill) begin
      last_addr <= ibus_addr[31:2];
      last_data <= ibus_rdata;
    end
  end
`else
  logic unused_inval;
  assign unused_inval = imem_inval;
  assign last_hit     = 1'b0;
  assign last_data    = INSTR_NOP;
`endif

  cpu_bootrom #(.ROM_WORDS(ROM_WORDS), .ROM_INIT(ROM_INIT)) u_rom (
    .clock (clock),
    .en    (advance && rom_hit),
    .addr  (p1_pc[2 +: AW]),
    .rdata (rom_data)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IMEM_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IMEM_IDLE: if (advance && !rom_hit && !last_hit) state_next = IMEM_WAIT;
      IMEM_WAIT: if (ibus_ack) state_next = IMEM_IDLE;
      default:   state_next = IMEM_IDLE;
    endcase
  end

  // Source select and external data only move on advance or fill, so p2_instr holds under stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      src       <= SRC_EXT;
      ext_data  <= INSTR_NOP;
      ibus_addr <= '0;
    end else begin
      if (advance) begin
        src <= rom_hit ? SRC_ROM : SRC_EXT;
        if (!rom_hit && last_hit)  ext_data  <= last_data;
        if (!rom_hit && !last_hit) ibus_addr <= {p1_pc[31:2], 2'b00};
      end
      if (fill) ext_data <= ibus_rdata;
    end
  end

  assign p2_instr = (src == SRC_ROM) ? rom_data : ext_data;

endmodule

// File: tb/tb_cpu_imem_resp.sv
// Scoreboard bench for cpu_imem_resp: accepted fetches push expected words, a monitor
// compares p2_instr whenever no external fetch is outstanding; a responder models the ibus.
module tb_cpu_imem_resp;
  localparam int ROM_WORDS = 1024;
`ifdef IMEM_LASTHIT_EN
  localparam bit LH = 1'b1;
`else
  localparam bit LH = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] p1_pc = 32'hFFFF_0000;
  logic [31:0] p2_instr;
  logic        ifetch_stall, ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack = 1'b0;
  logic [31:0] ibus_rdata = 32'h0;
  logic        imem_inval = 1'b0;

  cpu_imem_resp #(.ROM_WORDS(ROM_WORDS)) dut (
    .clock(clock), .reset(reset), .stall(stall), .p1_pc(p1_pc), .p2_instr(p2_instr),
    .ifetch_stall(ifetch_stall), .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata), .imem_inval(imem_inval)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] ext_mem [logic [31:0]];
  logic        m_valid = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_data = 32'h0;
  int          fixed_delay = -1;
  bit          force_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Reference contents: ROM word at offset/4 modulo depth, external memory by word address.
  function automatic logic [31:0] rom_val(input logic [31:0] pc);
    logic [31:0] i;
    i = ((pc & 32'h0000_FFFF) >> 2) % ROM_WORDS;
    return (i * 32'h9E37_79B1) ^ 32'hB007_0000;
  endfunction

  function automatic logic [31:0] ext_val(input logic [31:0] w);
    if (ext_mem.exists(w)) return ext_mem[w];
    return (w ^ 32'h1357_9BDF) + 32'h0101_0101;
  endfunction

  task automatic accept(input logic [31:0] pc);
    logic [31:0] w;
    w = {pc[31:2], 2'b00};
    if (pc[31:16] == 16'hFFFF) exp_q.push_back(rom_val(pc));
    else if (LH && m_valid && m_addr == w) exp_q.push_back(m_data);
    else begin
      exp_q.push_back(ext_val(w));
      addr_q.push_back(w);
    end
  endtask

  // Drive one cycle at the falling edge; decide acceptance just before the rising edge.
  task automatic cycle(input bit rst, input bit st, input logic [31:0] pc, input bit inv);
    @(negedge clock);
    reset = rst; stall = st; p1_pc = pc; imem_inval = inv;
    if (rst) begin
      exp_q.delete(); addr_q.delete(); m_valid = 1'b0;
    end
    #4;
    if (!rst && !stall && !ifetch_stall) accept(pc);
    if (!rst && inv && !ibus_ack) m_valid = 1'b0;
  endtask

  // External bus responder.
  initial begin
    int cnt;
    logic [31:0] a;
    cnt = 0;
    forever begin
      @(negedge clock);
      ibus_ack = 1'b0;
      if (force_ack) begin
        force_ack = 1'b0;
        ibus_ack = 1'b1;
        ibus_rdata = $urandom;
      end else if (reset || !ibus_req) begin
        cnt = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
      end else if (cnt > 0) begin
        cnt--;
      end else begin
        ibus_ack = 1'b1;
        if (addr_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_req: ibus_req with addr %08h, no external fetch expected", ibus_addr);
          ibus_rdata = 32'h0;
        end else begin
          a = addr_q.pop_front();
          check("ibus_addr", ibus_addr, a);
          ibus_rdata = ext_val(a);
          m_valid = 1'b1; m_addr = a; m_data = ibus_rdata;
        end
      end
    end
  end

  // Output monitor.
  initial begin
    int busy;
    bit dog;
    busy = 0; dog = 1'b0;
    forever begin
      @(negedge clock);
      #3;
      if (!reset) begin
        if (ifetch_stall) busy++; else busy = 0;
        if (busy > 12 && !dog) begin
          dog = 1'b1;
          n_chk++;
          $display("FAIL fetch_timeout: ifetch_stall high %0d cycles, limit 12", busy);
        end
        if (!ifetch_stall && exp_q.size() > 0) begin
          check("p2_instr", p2_instr, exp_q[0]);
          if (!stall) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] pool [4];
    logic [31:0] pc;
    bit st, inv;
    pool[0] = 32'h0000_1000; pool[1] = 32'h0000_2000;
    pool[2] = 32'h8000_0040; pool[3] = 32'hFFFE_FFFC;
    ext_mem[32'h0000_1000] = 32'hDEAD_BEEF;

    // reset, then first fetch from ROM
    cycle(1, 0, 32'hFFFF_0000, 0);
    cycle(1, 0, 32'hFFFF_0000, 0);
    cycle(0, 0, 32'hFFFF_0000, 0);
    check("rst_p2_instr", p2_instr, 32'h0);
    check("rst_ibus_req", 32'(ibus_req), 32'h0);
    check("rst_ifetch_stall", 32'(ifetch_stall), 32'h0);

    // back-to-back ROM
    cycle(0, 0, 32'hFFFF_0004, 0);
    check("rom_no_stall", 32'(ifetch_stall), 32'h0);
    cycle(0, 0, 32'hFFFF_0008, 0);
    check("rom_no_stall", 32'(ifetch_stall), 32'h0);

    // external fetch, ack in third wait cycle
    fixed_delay = 2;
    cycle(0, 0, 32'h0000_1000, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 32'hFFFF_0010, 0);
      check("ext_req", 32'(ibus_req), 32'h1);
      check("ext_addr", ibus_addr, 32'h0000_1000);
      check("ext_stall", 32'(ifetch_stall), 32'h1);
    end
    cycle(0, 0, 32'hFFFF_0010, 0);
    check("ext_req_drop", 32'(ibus_req), 32'h0);
    check("ext_data", p2_instr, 32'hDEAD_BEEF);

    // stall holds ROM output
    cycle(0, 0, 32'hFFFF_0004, 0);
    cycle(0, 1, 32'hFFFF_0040, 0);
    cycle(0, 1, 32'hFFFF_0040, 0);
    cycle(0, 0, 32'hFFFF_0040, 0);
    cycle(0, 0, 32'hFFFF_0000, 0);

    // reset during wait, then a stray ack
    fixed_delay = 5;
    cycle(0, 0, 32'h0000_2000, 0);
    cycle(0, 0, 32'hFFFF_0000, 0);
    check("wait_stall", 32'(ifetch_stall), 32'h1);
    cycle(1, 0, 32'hFFFF_0000, 0);
    cycle(0, 1, 32'hFFFF_0000, 0);
    check("rstw_req", 32'(ibus_req), 32'h0);
    check("rstw_p2", p2_instr, 32'h0);
    force_ack = 1'b1;
    cycle(0, 1, 32'hFFFF_0000, 0);
    cycle(0, 1, 32'hFFFF_0000, 0);
    check("late_ack_p2", p2_instr, 32'h0);
    check("late_ack_idle", 32'(ifetch_stall), 32'h0);
    check("late_ack_req", 32'(ibus_req), 32'h0);
    cycle(0, 0, 32'hFFFF_0000, 0);

`ifdef IMEM_LASTHIT_EN
    fixed_delay = 0;
    cycle(0, 0, 32'h0000_1000, 0);
    cycle(0, 0, 32'hFFFF_0000, 0);
    check("lh_fill_req", 32'(ibus_req), 32'h1);
    cycle(0, 0, 32'h0000_1000, 0);
    cycle(0, 0, 32'hFFFF_0000, 0);
    check("lh_hit_req", 32'(ibus_req), 32'h0);
    check("lh_hit_stall", 32'(ifetch_stall), 32'h0);
    cycle(0, 0, 32'hFFFF_0000, 1);
    cycle(0, 0, 32'h0000_1000, 0);
    cycle(0, 0, 32'hFFFF_0000, 0);
    check("lh_inval_req", 32'(ibus_req), 32'h1);
`endif

    // randomized traffic
    fixed_delay = -1;
    repeat (500) begin
      st  = ($urandom_range(0, 3) == 0);
      inv = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) pc = {16'hFFFF, 16'($urandom)};
      else begin
        pc = pool[$urandom_range(0, 3)];
        pc[1:0] = 2'($urandom);
      end
      cycle(0, st, pc, inv);
    end
    repeat (10) cycle(0, 0, 32'hFFFF_0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
